// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU command driver.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        GAP_A   = 3'd2,
        LOAD_B  = 3'd3,
        GAP_B   = 3'd4,
        LOAD_OP = 3'd5,
        WAIT    = 3'd6,
        RESP    = 3'd7
    } drv_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU model used to cross-check captured results.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_result_c,
    output logic               o_known_c
);

    always_comb begin
        o_result_c = '0;
        o_known_c  = 1'b1;
        case (i_op)
            NB_OP'(OP_ADD): o_result_c = i_a + i_b;
            NB_OP'(OP_SUB): o_result_c = i_a - i_b;
            NB_OP'(OP_AND): o_result_c = i_a & i_b;
            NB_OP'(OP_OR):  o_result_c = i_a | i_b;
            NB_OP'(OP_XOR): o_result_c = i_a ^ i_b;
            NB_OP'(OP_NOR): o_result_c = ~(i_a | i_b);
            NB_OP'(OP_SRA): o_result_c = $unsigned($signed(i_a) >>> i_b);
            NB_OP'(OP_SRL): o_result_c = i_a >> i_b;
            default:        o_known_c  = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequences one ALU command onto switch/button inputs and returns the captured result.
// Optional golden-model checking is enabled with the ALU_DRV_CHECK_EN macro.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA       = 8,
    parameter int unsigned NB_OP         = 6,
    parameter int unsigned PULSE_CYCLES  = 1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [NB_DATA-1:0] i_cmd_a,
    input  logic [NB_DATA-1:0] i_cmd_b,
    input  logic [NB_OP-1:0]   i_cmd_op,
    output logic [NB_DATA-1:0] o_dataSw,
    output logic [NB_OP-1:0]   o_opSw,
    output logic               o_btnA,
    output logic               o_btnB,
    output logic               o_btnO,
    input  logic [NB_DATA-1:0] i_resultLed,
    input  logic               i_overflowLed,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [NB_DATA-1:0] o_rsp_result,
    output logic               o_rsp_overflow,
    output logic               o_mismatch
);

    localparam int unsigned CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    drv_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] data_sw_q, data_sw_d;
    logic [NB_OP-1:0]   op_sw_q, op_sw_d;
    logic               btn_a_q, btn_a_d, btn_b_q, btn_b_d, btn_o_q, btn_o_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               capture_c;

    assign capture_c = (state_q == WAIT) && (cnt_q == '0);

    // Next state, timing counter, and outputs decoded from the next state so they align with it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        data_sw_d = data_sw_q;
        op_sw_d   = op_sw_q;
        result_d  = result_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    a_d     = i_cmd_a;
                    b_d     = i_cmd_b;
                    op_d    = i_cmd_op;
                    cnt_d   = PULSE_LD;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                if (cnt_q == '0) state_d = GAP_A;
                else             cnt_d   = cnt_q - 1'b1;
            end
            GAP_A: begin
                cnt_d   = PULSE_LD;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                if (cnt_q == '0) state_d = GAP_B;
                else             cnt_d   = cnt_q - 1'b1;
            end
            GAP_B: begin
                cnt_d   = PULSE_LD;
                state_d = LOAD_OP;
            end
            LOAD_OP: begin
                if (cnt_q == '0) begin
                    cnt_d   = SETTLE_LD;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (capture_c) begin
                    result_d = i_resultLed;
                    ovf_d    = i_overflowLed;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            LOAD_A, GAP_A:          data_sw_d = a_d;
            LOAD_B, GAP_B, LOAD_OP: data_sw_d = b_d;
            default: ;
        endcase
        if (state_d == LOAD_OP) op_sw_d = op_d;

        btn_a_d     = (state_d == LOAD_A);
        btn_b_d     = (state_d == LOAD_B);
        btn_o_d     = (state_d == LOAD_OP);
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            data_sw_q   <= '0;
            op_sw_q     <= '0;
            btn_a_q     <= 1'b0;
            btn_b_q     <= 1'b0;
            btn_o_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            data_sw_q   <= data_sw_d;
            op_sw_q     <= op_sw_d;
            btn_a_q     <= btn_a_d;
            btn_b_q     <= btn_b_d;
            btn_o_q     <= btn_o_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef ALU_DRV_CHECK_EN
    logic [NB_DATA-1:0] ref_result;
    logic               ref_known;
    logic               mismatch_q, mismatch_d;

    alu_ref_model #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_ref_model (
        .i_a        (a_q),
        .i_b        (b_q),
        .i_op       (op_q),
        .o_result_c (ref_result),
        .o_known_c  (ref_known)
    );

    // Flag evaluated against the live ALU result on the capture edge.
    always_comb begin
        mismatch_d = mismatch_q;
        if (capture_c) mismatch_d = ref_known && (ref_result != i_resultLed);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) mismatch_q <= 1'b0;
        else         mismatch_q <= mismatch_d;
    end

    assign o_mismatch = mismatch_q;
`else
    assign o_mismatch = 1'b0;
`endif

    assign o_cmd_ready    = cmd_ready_q;
    assign o_dataSw       = data_sw_q;
    assign o_opSw         = op_sw_q;
    assign o_btnA         = btn_a_q;
    assign o_btnB         = btn_b_q;
    assign o_btnO         = btn_o_q;
    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_result   = result_q;
    assign o_rsp_overflow = ovf_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench: drives commands into alu_cmd_driver with a behavioural ALU top behind it.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [5:0] cmd_op;
    logic [7:0] data_sw;
    logic [5:0] op_sw;
    logic       btn_a, btn_b, btn_o;
    logic [7:0] result_led;
    logic       ovf_led;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_ovf;
    logic       mismatch;

    int n_vec = 0;
    int n_err = 0;

`ifdef ALU_DRV_CHECK_EN
    localparam logic CHK_ON = 1'b1;
`else
    localparam logic CHK_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_cmd_driver dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_a        (cmd_a),
        .i_cmd_b        (cmd_b),
        .i_cmd_op       (cmd_op),
        .o_dataSw       (data_sw),
        .o_opSw         (op_sw),
        .o_btnA         (btn_a),
        .o_btnB         (btn_b),
        .o_btnO         (btn_o),
        .i_resultLed    (result_led),
        .i_overflowLed  (ovf_led),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_result   (rsp_result),
        .o_rsp_overflow (rsp_ovf),
        .o_mismatch     (mismatch)
    );

    // Behavioural ALU top: registers latch on their buttons; stub_zero forces a wrong result.
    logic [7:0] alu_a = '0, alu_b = '0;
    logic [5:0] alu_op = '0;
    logic       stub_zero = 1'b0;

    always @(posedge clk) begin
        if (btn_a) alu_a  <= data_sw;
        if (btn_b) alu_b  <= data_sw;
        if (btn_o) alu_op <= op_sw;
    end

    always_comb begin
        logic [7:0] r;
        r       = 8'h00;
        ovf_led = 1'b0;
        case (alu_op)
            OP_ADD: begin r = alu_a + alu_b; ovf_led = (alu_a[7] == alu_b[7]) && (r[7] != alu_a[7]); end
            OP_SUB: begin r = alu_a - alu_b; ovf_led = (alu_a[7] != alu_b[7]) && (r[7] != alu_a[7]); end
            OP_AND: r = alu_a & alu_b;
            OP_OR:  r = alu_a | alu_b;
            OP_XOR: r = alu_a ^ alu_b;
            OP_NOR: r = ~(alu_a | alu_b);
            OP_SRA: r = $unsigned($signed(alu_a) >>> alu_b);
            OP_SRL: r = alu_a >> alu_b;
            default: r = 8'h00;
        endcase
        result_led = stub_zero ? 8'h00 : r;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One command end to end: pulse order, latency, captured fields, hold and release.
    task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] op, input logic [7:0] exp_res,
                           input logic exp_ovf, input logic exp_mis, input int hold);
        int k, pa, pb, po, na, nb, no, overlap, busy_ready;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_op = 6'h3F;
        k = 0; pa = -1; pb = -1; po = -1; na = 0; nb = 0; no = 0; overlap = 0; busy_ready = 0;
        while (!rsp_valid && k < 30) begin
            if (btn_a) begin na++; if (pa < 0) pa = k; end
            if (btn_b) begin nb++; if (pb < 0) pb = k; end
            if (btn_o) begin no++; if (po < 0) po = k; end
            if (int'(btn_a) + int'(btn_b) + int'(btn_o) > 1) overlap++;
            if (cmd_ready) busy_ready++;
            @(posedge clk); #1;
            k++;
        end
        check({tag, ".latency"}, 32'(k), 32'd7);
        check({tag, ".btn_pos"}, {8'(pa), 8'(pb), 8'(po)}, {8'd0, 8'd2, 8'd4});
        check({tag, ".btn_cnt"}, {8'(na), 8'(nb), 8'(no)}, {8'd1, 8'd1, 8'd1});
        check({tag, ".btn_overlap"}, 32'(overlap), 32'd0);
        check({tag, ".busy_ready"}, 32'(busy_ready), 32'd0);
        check({tag, ".sw_hold"}, {data_sw, 2'b00, op_sw}, {b, 2'b00, op});
        check({tag, ".result"}, {23'd0, rsp_ovf, rsp_result}, {23'd0, exp_ovf, exp_res});
        check({tag, ".mismatch"}, 32'(mismatch), 32'(exp_mis));
        repeat (hold) @(posedge clk);
        #1;
        if (hold > 0)
            check({tag, ".held"}, {rsp_valid, cmd_ready, rsp_ovf, rsp_result},
                  {1'b1, 1'b0, exp_ovf, exp_res});
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, ".release"}, {rsp_valid, cmd_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        int k, seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ctrl", {cmd_ready, rsp_valid, btn_a, btn_b, btn_o, mismatch, rsp_ovf},
              7'b1000000);
        check("reset.data", {data_sw, op_sw, rsp_result}, 22'd0);
        @(negedge clk);
        rst = 1'b0;

        run_cmd("add_basic", 8'h05, 8'h03, OP_ADD, 8'h08, 1'b0, 1'b0, 0);
        run_cmd("add_ovf",   8'h7F, 8'h01, OP_ADD, 8'h80, 1'b1, 1'b0, 0);
        run_cmd("sra",       8'h80, 8'h02, OP_SRA, 8'hE0, 1'b0, 1'b0, 0);
        run_cmd("srl",       8'h80, 8'h02, OP_SRL, 8'h20, 1'b0, 1'b0, 0);
        run_cmd("sub_hold",  8'h03, 8'h05, OP_SUB, 8'hFE, 1'b0, 1'b0, 5);
        run_cmd("xor",       8'h0F, 8'hFF, OP_XOR, 8'hF0, 1'b0, 1'b0, 0);
        run_cmd("nor",       8'h0F, 8'hF0, OP_NOR, 8'h00, 1'b0, 1'b0, 0);
        run_cmd("unknown",   8'h12, 8'h34, 6'b111111, 8'h00, 1'b0, 1'b0, 0);

        stub_zero = 1'b1;
        run_cmd("stub_and",  8'h01, 8'h01, OP_AND, 8'h00, 1'b0, CHK_ON, 0);
        stub_zero = 1'b0;

        // Reset in the middle of LOAD_B must abandon the command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = OP_OR;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (!btn_b && k < 20) begin @(posedge clk); #1; k++; end
        check("rst_mid.reach_load_b", 32'(btn_b), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid.after", {btn_a, btn_b, btn_o, cmd_ready, rsp_valid, data_sw},
              {5'b00010, 8'h00});
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        check("rst_mid.no_rsp", 32'(seen), 32'd0);

        run_cmd("post_rst", 8'h0A, 8'h05, OP_OR, 8'h0F, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 Parameter NB_DATA, default 8, shall set the operand/result width.
REQ-002 Parameter NB_OP, default 6, shall set the opcode width.
REQ-003 Parameter PULSE_CYCLES, default 1 (legal >=1), shall set the cycles each button is held high.
REQ-004 Parameter SETTLE_CYCLES, default 2 (legal >=1), shall set the wait after the op button before result capture.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_cmd_valid / o_cmd_ready  in/out  1/1  command handshake; transfer when both high at an edge.
REQ-008 i_cmd_a, i_cmd_b  in  NB_DATA  operands; i_cmd_op  in  NB_OP  opcode.
REQ-009 o_dataSw  out  NB_DATA  switch data toward the ALU top; o_opSw  out  NB_OP  opcode switches.
REQ-010 o_btnA, o_btnB, o_btnO  out  1  load strobes for operand A, operand B, opcode.
REQ-011 i_resultLed  in  NB_DATA, i_overflowLed  in  1  ALU top outputs.
REQ-012 o_rsp_valid / i_rsp_ready  out/in  1/1  response handshake; o_rsp_result  out  NB_DATA; o_rsp_overflow  out  1.
REQ-013 o_mismatch  out  1  per-response check flag, valid with o_rsp_valid.

Function
REQ-014 FSM states shall be IDLE, LOAD_A, GAP_A, LOAD_B, GAP_B, LOAD_OP, WAIT, RESP.
REQ-015 o_cmd_ready shall be high exactly when state is IDLE.
REQ-016 On accept, a/b/op shall be registered and state shall go LOAD_A; i_cmd_* ignored until next IDLE.
REQ-017 LOAD_A shall drive o_dataSw=A, o_btnA=1 for PULSE_CYCLES cycles, then GAP_A one cycle with o_dataSw=A, all buttons 0.
REQ-018 LOAD_B shall drive o_dataSw=B, o_btnB=1 for PULSE_CYCLES cycles, then GAP_B one cycle, all buttons 0.
REQ-019 LOAD_OP shall drive o_opSw=op, o_btnO=1 for PULSE_CYCLES cycles; o_dataSw held at B.
REQ-020 o_dataSw and o_opSw shall hold their last value outside the states driving them; at most one button high in any cycle.
REQ-021 WAIT shall last SETTLE_CYCLES cycles; on its last edge i_resultLed/i_overflowLed shall be captured into o_rsp_result/o_rsp_overflow and state shall go RESP.
REQ-022 o_rsp_valid shall be high exactly in RESP; response fields stable while valid and not ready.
REQ-023 RESP with i_rsp_ready=1 shall return to IDLE next edge; no command accepted in the same cycle.
REQ-024 Latency from accept edge to o_rsp_valid rising shall be 3*PULSE_CYCLES+2+SETTLE_CYCLES cycles (7 with defaults).
REQ-025 A single internal down-counter, NB width sized for max(PULSE_CYCLES,SETTLE_CYCLES), shall time all timed states.

Reset
REQ-026 i_reset high at an edge shall force IDLE from any state, dropping any in-flight command or pending response.
REQ-027 Reset values: o_dataSw=0, o_opSw=0, all buttons 0, o_rsp_valid=0, o_rsp_result=0, o_rsp_overflow=0, o_mismatch=0, counter=0.

Configuration
REQ-028 Macro ALU_DRV_CHECK_EN defined: o_mismatch shall be 1 when captured result differs from the golden model of the registered a/b/op (ADD, SUB, AND, OR, XOR, NOR, SRA, SRL; SRA/SRL shift A by B; unknown opcode never mismatches); computed at capture.
REQ-029 Macro undefined: o_mismatch shall be tied 0 and no model logic synthesized.

Structure
REQ-030 Shared package alu_pkg shall hold opcode constants (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010) and the FSM state enum.
REQ-031 Golden model shall be sub-module alu_ref_model, instantiated only under ALU_DRV_CHECK_EN.

Verification
REQ-032 Reset, then cmd a=8'h05 b=8'h03 op=ADD against TOP -> btnA/btnB/btnO single pulses in order, o_rsp_valid at 7 cycles, result 8'h08, overflow 0.
REQ-033 a=8'h7F b=8'h01 ADD -> result 8'h80, overflow 1, o_mismatch 0 with ALU_DRV_CHECK_EN.
REQ-034 a=8'h80 b=8'h02 SRA then SRL -> results 8'hE0 and 8'h20.
REQ-035 i_rsp_ready held 0 for 5 cycles -> response held stable, o_cmd_ready 0; ready=1 -> IDLE next edge.
REQ-036 i_reset pulsed during LOAD_B -> next edge buttons 0, IDLE, o_rsp_valid never asserts for that command.
REQ-037 Stubbed ALU returning 8'h00 for a=1 b=1 AND, macro on -> o_mismatch 1; macro off -> 0.
